s08_uart: RTL

Register-mapped serial port (8N1 UART) on the MiniS08 I/O window, abus 0x004–0x007. It sits directly on the CPU data/address bus and feeds received bytes onto dbus. It also takes bytes from dbus and shifts them out on txd. It is a drop-in replacement for the current serial peripheral, adding a receive FIFO, a programmable baud divisor and sticky error flags.

---
 rtl/s08_uart_pkg.sv | 34 +++
 rtl/s08_uart_rx_fifo.sv | 69 ++++++
 rtl/s08_uart.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s08_uart_pkg.sv
// s08_uart_pkg: shared constants for the MiniS08 serial port.
// Holds the register offsets inside the I/O window, the STATUS bit positions,
// the TX/RX state encodings and the baud divisor width.
package s08_uart_pkg;

  localparam int unsigned DIV_W = 12;

  // Register offsets on abus[2:0]; offsets 0-3 belong to the FPU window.
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_DATA   = 3'd5;
  localparam logic [2:0] REG_BDL    = 3'd6;
  localparam logic [2:0] REG_BDH    = 3'd7;

  // STATUS bit positions.
  localparam int unsigned ST_RDRF   = 0;
  localparam int unsigned ST_TDRE   = 1;
  localparam int unsigned ST_TC     = 2;
  localparam int unsigned ST_OR     = 3;
  localparam int unsigned ST_FE     = 4;
  localparam int unsigned ST_RXFULL = 5;

  // Transmit engine states.
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // Receive engine states.
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/s08_uart_rx_fifo.sv
// s08_uart_rx_fifo: receive byte FIFO for the serial port.
// Ports: clk50/resetin (async active-low), push/wdata write side,
// pop/head read side (head is the oldest byte, valid while !empty),
// count of stored bytes, full/empty flags.
// A pop and a push in the same cycle while full both succeed.
module s08_uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk50,
  input  logic                     resetin,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // The pop frees a slot first, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk50 or negedge resetin) begin
    if (!resetin) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful behind the occupancy count.
  always_ff @(posedge clk50) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/s08_uart.sv
// s08_uart: 8N1 serial port on the MiniS08 I/O window (abus 0x004-0x007).
// Ports: clk50/resetin (async active-low), CPU bus din/dout/sel/addr/rd/wr,
// serial rxd (idle high) and txd (idle high).
// Registers: 4 STATUS (W1C OR/FE), 5 DATA (RX FIFO head / TX holding),
// 6 BDL and 7 BDH (12-bit baud divisor). dout is combinational while sel&rd.
module s08_uart
  import s08_uart_pkg::*;
#(
  parameter int unsigned RX_DEPTH    = 4,
  parameter int unsigned DEFAULT_DIV = 326,
  parameter int unsigned OVS         = 16
) (
  input  logic       clk50,
  input  logic       resetin,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       sel,
  input  logic [2:0] addr,
  input  logic       rd,
  input  logic       wr,
  input  logic       rxd,
  output logic       txd
);

  localparam int unsigned CW  = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int unsigned FCW = $clog2(RX_DEPTH) + 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] TICK_MID  = CW'(OVS / 2 - 1);

  logic             sel_wr_c, sel_rd_c;
  logic             wr_s_q, wr_s_d, wr_fire_q, wr_fire_d;
  logic             rd_s_q, rd_s_d;
  logic [2:0]       rd_addr_q, rd_addr_d;
  logic             rxd_s1_q, rxd_s1_d, rxd_s2_q, rxd_s2_d, rxd_d1_q, rxd_d1_d;
  logic             rx_fall_c;
  logic [DIV_W-1:0] div_q, div_d, presc_q, presc_d, div_eff_c;
  logic             tick_c;
  logic [1:0]       tx_state_q, tx_state_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
  logic             tdre_q, tdre_d, txd_q, txd_d, tx_load_c;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_push_c, rx_fe_set_c;
  logic             or_q, or_d, fe_q, fe_d, or_set_c;
  logic             fifo_pop_c, fifo_full, fifo_empty;
  logic [7:0]       fifo_head, status_c;
  logic [FCW-1:0]   fifo_count;

  assign sel_wr_c = sel & wr;
  assign sel_rd_c = sel & rd;

  // Strobe edge detection and rxd synchroniser.
  always_comb begin
    wr_s_d    = sel_wr_c;
    wr_fire_d = sel_wr_c & ~wr_s_q;
    rd_s_d    = sel_rd_c;
    rd_addr_d = (sel_rd_c & ~rd_s_q) ? addr : rd_addr_q;
    rxd_s1_d  = rxd;
    rxd_s2_d  = rxd_s1_q;
    rxd_d1_d  = rxd_s2_q;
  end

  assign rx_fall_c  = rxd_d1_q & ~rxd_s2_q;
  // The DATA pop waits for the read strobe to end so the CPU sees a stable head.
  assign fifo_pop_c = rd_s_q & ~sel_rd_c & (rd_addr_q == REG_DATA) & ~fifo_empty;
  assign or_set_c   = rx_push_c & fifo_full & ~fifo_pop_c;

  assign div_eff_c = (div_q == '0) ? DIV_W'(1) : div_q;
  assign tick_c    = (presc_q >= div_eff_c - DIV_W'(1));

  // Register writes, sticky flags and prescaler.
  always_comb begin
    div_d     = div_q;
    tx_hold_d = tx_hold_q;
    tdre_d    = tdre_q;
    or_d      = or_q;
    fe_d      = fe_q;
    presc_d   = tick_c ? '0 : presc_q + DIV_W'(1);
    if (tx_load_c) tdre_d = 1'b1;
    if (wr_fire_q) begin
      case (addr)
        REG_STATUS: begin
          if (din[ST_OR]) or_d = 1'b0;
          if (din[ST_FE]) fe_d = 1'b0;
        end
        REG_DATA: begin
          if (tdre_q) begin
            tx_hold_d = din;
            tdre_d    = 1'b0;
          end
        end
        REG_BDL: begin
          div_d[7:0] = din;
          presc_d    = '0;
        end
        REG_BDH: begin
          div_d[11:8] = din[3:0];
          presc_d     = '0;
        end
        default: ;
      endcase
    end
    if (or_set_c)    or_d = 1'b1;
    if (rx_fe_set_c) fe_d = 1'b1;
  end

  // Transmit engine: one bit per OVS ticks, reloads without a gap when a byte waits.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_load_c  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tdre_q) begin
          tx_load_c  = 1'b1;
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
        end
      end
      TX_START: begin
        if (tick_c) begin
          if (tx_cnt_q == TICK_LAST) begin
            tx_state_d = TX_DATA;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
      end
      TX_DATA: begin
        if (tick_c) begin
          if (tx_cnt_q == TICK_LAST) begin
            tx_cnt_d   = '0;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            else                  tx_bit_d   = tx_bit_q + 3'd1;
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
      end
      TX_STOP: begin
        if (tick_c) begin
          if (tx_cnt_q == TICK_LAST) begin
            tx_cnt_d = '0;
            if (!tdre_q) begin
              tx_load_c  = 1'b1;
              tx_state_d = TX_START;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_load_c) tx_shift_d = tx_hold_q;
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // Receive engine: realigns to mid start bit, then samples every OVS ticks.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push_c   = 1'b0;
    rx_fe_set_c = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall_c) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (tick_c) begin
          if (rx_cnt_q == TICK_MID) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      end
      RX_DATA: begin
        if (tick_c) begin
          if (rx_cnt_q == TICK_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      end
      RX_STOP: begin
        if (tick_c) begin
          if (rx_cnt_q == TICK_LAST) begin
            rx_cnt_d    = '0;
            rx_push_c   = rxd_s2_q;
            rx_fe_set_c = ~rxd_s2_q;
            rx_state_d  = RX_IDLE;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge resetin) begin
    if (!resetin) begin
      wr_s_q     <= 1'b0;
      wr_fire_q  <= 1'b0;
      rd_s_q     <= 1'b0;
      rd_addr_q  <= '0;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_d1_q   <= 1'b1;
      div_q      <= DIV_W'(DEFAULT_DIV);
      presc_q    <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      tdre_q     <= 1'b1;
      txd_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      or_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      wr_s_q     <= wr_s_d;
      wr_fire_q  <= wr_fire_d;
      rd_s_q     <= rd_s_d;
      rd_addr_q  <= rd_addr_d;
      rxd_s1_q   <= rxd_s1_d;
      rxd_s2_q   <= rxd_s2_d;
      rxd_d1_q   <= rxd_d1_d;
      div_q      <= div_d;
      presc_q    <= presc_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tdre_q     <= tdre_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      or_q       <= or_d;
      fe_q       <= fe_d;
    end
  end

  s08_uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk50   (clk50),
    .resetin (resetin),
    .push    (rx_push_c),
    .wdata   (rx_shift_q),
    .pop     (fifo_pop_c),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // STATUS image.
  always_comb begin
    status_c            = '0;
    status_c[ST_RDRF]   = ~fifo_empty;
    status_c[ST_TDRE]   = tdre_q;
    status_c[ST_TC]     = tdre_q & (tx_state_q == TX_IDLE);
    status_c[ST_OR]     = or_q;
    status_c[ST_FE]     = fe_q;
    status_c[ST_RXFULL] = (fifo_count == FCW'(RX_DEPTH));
  end

  // Read mux; the bus sees 0x00 whenever it is not reading this window.
  always_comb begin
    dout = 8'h00;
    if (sel_rd_c) begin
      case (addr)
        REG_STATUS: dout = status_c;
        REG_DATA:   dout = fifo_empty ? 8'h00 : fifo_head;
        REG_BDL:    dout = div_q[7:0];
        REG_BDH:    dout = {4'h0, div_q[11:8]};
        default:    dout = 8'h00;
      endcase
    end
  end

  assign txd = txd_q;

endmodule
